// File: rtl/delay_ctrl.sv
// ---------------------------------------------------------------------------
// delay_ctrl
// Sequencing controller for the mic delay-line datapath. It drives the write
// and read ports of a dual-port RAM from a sample-tick state machine, mutes
// the output until enough history has been written, and accepts run-time
// delay (offset) changes through a valid/ready handshake. Offset changes are
// applied only on sample boundaries.
//
// Optional feature macro: DELAY_RAMP_EN
//   defined   : a pending offset is approached by +/-1 per tick. There is no
//               FILL re-entry, and cfg_ready stays low until the target is
//               reached.
//   undefined : the offset is applied as a single step. An increase re-enters
//               FILL for (new - old) write-only ticks.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   en           run enable (0 forces IDLE and clears pointer/fill count)
//   sample_tick  one-cycle strobe per audio sample
//   cfg_valid    new offset offered
//   cfg_offset   requested delay in samples
//   cfg_ready    controller can accept an offset
//   wr_en        RAM write strobe (registered, one cycle)
//   rd_en        RAM read strobe (registered, one cycle)
//   wr_addr      RAM write address (registered)
//   rd_addr      RAM read address (registered)
//   mute         1 = RAM read data is stale, downstream outputs zero
//   state        IDLE=00, FILL=01, RUN=10
// ---------------------------------------------------------------------------
module delay_ctrl #(
  parameter int A_WIDTH      = 9,
  parameter int RESET_OFFSET = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sample_tick,
  input  logic               cfg_valid,
  input  logic [A_WIDTH-1:0] cfg_offset,
  output logic               cfg_ready,
  output logic               wr_en,
  output logic               rd_en,
  output logic [A_WIDTH-1:0] wr_addr,
  output logic [A_WIDTH-1:0] rd_addr,
  output logic               mute,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_FILL = 2'b01,
    S_RUN  = 2'b10
  } state_t;

  localparam logic [A_WIDTH-1:0] ADDR_ZERO   = A_WIDTH'(0);
  localparam logic [A_WIDTH-1:0] ADDR_ONE    = A_WIDTH'(1);
  localparam logic [A_WIDTH-1:0] OFFSET_INIT = A_WIDTH'(RESET_OFFSET);

  state_t             r_state, w_state_nx;
  logic [A_WIDTH-1:0] r_ptr, w_ptr_nx;
  logic [A_WIDTH-1:0] r_fill_cnt, w_fill_nx;
  logic [A_WIDTH-1:0] r_offset, w_offset_nx;
  logic [A_WIDTH-1:0] r_pend_val, w_pend_val_nx;
  logic               r_pend_valid, w_pend_valid_nx;
  logic               r_cfg_ready, w_cfg_ready_nx;
  logic               r_wr_en, w_wr_en_nx;
  logic               r_rd_en, w_rd_en_nx;
  logic [A_WIDTH-1:0] r_wr_addr, w_wr_addr_nx;
  logic [A_WIDTH-1:0] r_rd_addr, w_rd_addr_nx;
  logic               r_mute, w_mute_nx;
  logic               w_grow;
  logic [A_WIDTH-1:0] w_fill_base;

  // Next-state, next-output and handshake logic
  always_comb begin
    w_state_nx      = r_state;
    w_ptr_nx        = r_ptr;
    w_fill_nx       = r_fill_cnt;
    w_offset_nx     = r_offset;
    w_pend_val_nx   = r_pend_val;
    w_pend_valid_nx = r_pend_valid;
    w_wr_en_nx      = 1'b0;
    w_rd_en_nx      = 1'b0;
    w_wr_addr_nx    = r_wr_addr;
    w_rd_addr_nx    = r_rd_addr;
    w_mute_nx       = r_mute;
    w_grow          = 1'b0;
    w_fill_base     = r_fill_cnt;

    if (!en) begin
      // Disable: no strobes, back to IDLE; offset and pending value survive.
      w_state_nx = S_IDLE;
      w_ptr_nx   = ADDR_ZERO;
      w_fill_nx  = ADDR_ZERO;
      w_mute_nx  = 1'b1;
      if ((r_state == S_IDLE) && r_pend_valid) begin
        w_offset_nx     = r_pend_val;
        w_pend_valid_nx = 1'b0;
      end else begin
        w_offset_nx = r_offset;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          w_mute_nx = 1'b1;
          if (r_pend_valid) begin
            w_offset_nx     = r_pend_val;
            w_pend_valid_nx = 1'b0;
          end else begin
            w_offset_nx = r_offset;
          end
          // A zero delay needs no history, so FILL is skipped.
          if (w_offset_nx == ADDR_ZERO) begin
            w_state_nx = S_RUN;
          end else begin
            w_state_nx = S_FILL;
          end
        end
        S_FILL, S_RUN: begin
          if (sample_tick) begin
            // A value captured on this very edge is not yet in r_pend_valid,
            // so a tick in the capture cycle still uses the old offset.
            if (r_pend_valid) begin
`ifdef DELAY_RAMP_EN
              if (r_pend_val > r_offset) begin
                w_offset_nx = r_offset + ADDR_ONE;
              end else if (r_pend_val < r_offset) begin
                w_offset_nx = r_offset - ADDR_ONE;
              end else begin
                w_offset_nx = r_offset;
              end
              w_pend_valid_nx = (w_offset_nx != r_pend_val);
`else
              w_offset_nx     = r_pend_val;
              w_pend_valid_nx = 1'b0;
              w_grow          = (r_pend_val > r_offset);
`endif
            end else begin
              w_offset_nx = r_offset;
            end

            w_wr_en_nx   = 1'b1;
            w_wr_addr_nx = r_ptr;
            w_ptr_nx     = r_ptr + ADDR_ONE;

            if ((r_state == S_RUN) && !w_grow) begin
              w_rd_en_nx   = 1'b1;
              w_rd_addr_nx = r_ptr - w_offset_nx;
              w_mute_nx    = 1'b0;
            end else begin
              // Leaving RUN on a step increase: exactly old-offset samples
              // of history already exist. Inside FILL the count carries on.
              if (r_state == S_RUN) begin
                w_fill_base = r_offset;
              end else begin
                w_fill_base = r_fill_cnt;
              end
              w_fill_nx = w_fill_base + ADDR_ONE;
              w_mute_nx = 1'b1;
              // >= so that a decrease below the current count exits FILL.
              if (w_fill_nx >= w_offset_nx) begin
                w_state_nx = S_RUN;
              end else begin
                w_state_nx = S_FILL;
              end
            end
          end else begin
            w_state_nx = r_state;
          end
        end
        default: begin
          w_state_nx = S_IDLE;
          w_mute_nx  = 1'b1;
        end
      endcase
    end

    // Capture a new offset. A capture can only happen with nothing pending,
    // so it never collides with an application in the same cycle.
    if (cfg_valid && r_cfg_ready) begin
      w_pend_valid_nx = 1'b1;
      w_pend_val_nx   = cfg_offset;
    end else begin
      w_pend_val_nx = w_pend_val_nx;
    end

    w_cfg_ready_nx = !w_pend_valid_nx;
  end

  // State, datapath and registered output flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= ADDR_ZERO;
      r_fill_cnt   <= ADDR_ZERO;
      r_offset     <= OFFSET_INIT;
      r_pend_val   <= ADDR_ZERO;
      r_pend_valid <= 1'b0;
      r_cfg_ready  <= 1'b1;
      r_wr_en      <= 1'b0;
      r_rd_en      <= 1'b0;
      r_wr_addr    <= ADDR_ZERO;
      r_rd_addr    <= ADDR_ZERO;
      r_mute       <= 1'b1;
    end else begin
      r_state      <= w_state_nx;
      r_ptr        <= w_ptr_nx;
      r_fill_cnt   <= w_fill_nx;
      r_offset     <= w_offset_nx;
      r_pend_val   <= w_pend_val_nx;
      r_pend_valid <= w_pend_valid_nx;
      r_cfg_ready  <= w_cfg_ready_nx;
      r_wr_en      <= w_wr_en_nx;
      r_rd_en      <= w_rd_en_nx;
      r_wr_addr    <= w_wr_addr_nx;
      r_rd_addr    <= w_rd_addr_nx;
      r_mute       <= w_mute_nx;
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign wr_en     = r_wr_en;
  assign rd_en     = r_rd_en;
  assign wr_addr   = r_wr_addr;
  assign rd_addr   = r_rd_addr;
  assign mute      = r_mute;
  assign state     = r_state;

endmodule

// File: tb/tb_delay_ctrl.sv
// ---------------------------------------------------------------------------
// tb_delay_ctrl
// Directed self-checking bench for delay_ctrl with A_WIDTH=9 and
// RESET_OFFSET=4. Inputs are driven on the falling edge and outputs are
// sampled on the falling edge, half a cycle after the active rising edge.
// Optional feature macro: DELAY_RAMP_EN selects the ramped expectations.
// ---------------------------------------------------------------------------
module tb_delay_ctrl;

  localparam int AW = 9;

  logic          clk;
  logic          rst;
  logic          en;
  logic          sample_tick;
  logic          cfg_valid;
  logic [AW-1:0] cfg_offset;
  logic          cfg_ready;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          mute;
  logic [1:0]    state;

  int n_checks = 0;
  int n_errors = 0;

  delay_ctrl #(
    .A_WIDTH      (AW),
    .RESET_OFFSET (4)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .sample_tick (sample_tick),
    .cfg_valid   (cfg_valid),
    .cfg_offset  (cfg_offset),
    .cfg_ready   (cfg_ready),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .mute        (mute),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One tick, check the resulting strobes/addresses, then one quiet cycle
  // to confirm the strobes are a single cycle wide.
  task automatic tick_chk(input string tag, input logic exp_rd, input int exp_wa,
                          input int exp_ra, input logic exp_mute);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    check({tag, ".wr_en"},   32'(wr_en),   32'd1);
    check({tag, ".wr_addr"}, 32'(wr_addr), 32'(exp_wa));
    check({tag, ".rd_en"},   32'(rd_en),   32'(exp_rd));
    if (exp_rd) begin
      check({tag, ".rd_addr"}, 32'(rd_addr), 32'(exp_ra));
    end
    check({tag, ".mute"}, 32'(mute), 32'(exp_mute));
    @(negedge clk);
    check({tag, ".pulse"}, 32'({wr_en, rd_en}), 32'd0);
  endtask

  task automatic fast_tick();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic offer_cfg(input logic [AW-1:0] val);
    cfg_valid  = 1'b1;
    cfg_offset = val;
    @(negedge clk);
    cfg_valid  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    en          = 1'b0;
    sample_tick = 1'b0;
    cfg_valid   = 1'b0;
    cfg_offset  = 9'd0;

    // Reset values
    @(negedge clk);
    check("rst.state",     32'(state),     32'd0);
    check("rst.mute",      32'(mute),      32'd1);
    check("rst.cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst.strobes",   32'({wr_en, rd_en}), 32'd0);
    check("rst.wr_addr",   32'(wr_addr),   32'd0);
    check("rst.rd_addr",   32'(rd_addr),   32'd0);
    rst = 1'b0;

    // Enable: IDLE -> FILL, four write-only ticks, then the first read
    en = 1'b1;
    @(negedge clk);
    check("en.state_fill", 32'(state), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick_chk("fill", 1'b0, i, 0, 1'b1);
    end
    check("fill.state_run", 32'(state), 32'd2);
    tick_chk("first_read", 1'b1, 4, 0, 1'b0);

    // Run to the address wrap with offset 4
    for (int i = 5; i <= 510; i++) begin
      fast_tick();
    end
    tick_chk("wrap511", 1'b1, 511, 507, 1'b0);
    tick_chk("wrap0",   1'b1, 0,   508, 1'b0);
    tick_chk("wrap1",   1'b1, 1,   509, 1'b0);
    tick_chk("wrap2",   1'b1, 2,   510, 1'b0);

`ifdef DELAY_RAMP_EN
    // Ramp 4 -> 8: offsets 5,6,7,8 over four ticks, no mute
    offer_cfg(9'd8);
    check("ramp.cfg_ready_lo", 32'(cfg_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick_chk("ramp", 1'b1, 3 + i, 510, 1'b0);
    end
    check("ramp.cfg_ready_hi", 32'(cfg_ready), 32'd1);

    // Decrease offered with a tick: that tick uses offset 8, next steps to 7
    cfg_valid   = 1'b1;
    cfg_offset  = 9'd2;
    sample_tick = 1'b1;
    @(negedge clk);
    cfg_valid   = 1'b0;
    sample_tick = 1'b0;
    check("coinc.rd_addr",   32'(rd_addr),   32'd511);
    check("coinc.cfg_ready", 32'(cfg_ready), 32'd0);
    @(negedge clk);
    tick_chk("dec", 1'b1, 8, 1, 1'b0);
`else
    // Step increase 4 -> 10: six write-only muted ticks, then RUN
    offer_cfg(9'd10);
    check("inc.cfg_ready_lo", 32'(cfg_ready), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick_chk("inc_fill", 1'b0, 3 + i, 0, 1'b1);
      if (i == 0) begin
        check("inc.cfg_ready_hi", 32'(cfg_ready), 32'd1);
      end
    end
    check("inc.state_run", 32'(state), 32'd2);
    tick_chk("inc_read", 1'b1, 9, 511, 1'b0);

    // Decrease offered with a tick: that tick uses 10, the next uses 2
    cfg_valid   = 1'b1;
    cfg_offset  = 9'd2;
    sample_tick = 1'b1;
    @(negedge clk);
    cfg_valid   = 1'b0;
    sample_tick = 1'b0;
    check("coinc.rd_addr",   32'(rd_addr),   32'd0);
    check("coinc.cfg_ready", 32'(cfg_ready), 32'd0);
    @(negedge clk);
    tick_chk("dec", 1'b1, 11, 9, 1'b0);
    check("dec.cfg_ready", 32'(cfg_ready), 32'd1);
`endif

    // en=0 together with a tick: no strobe, IDLE next cycle
    en          = 1'b0;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    check("dis.strobes", 32'({wr_en, rd_en}), 32'd0);
    check("dis.state",   32'(state), 32'd0);
    check("dis.mute",    32'(mute),  32'd1);
    @(negedge clk);

    // Offset 0 in IDLE, then enable: FILL skipped, rd_addr == wr_addr
    offer_cfg(9'd0);
    check("zero.cfg_ready_lo", 32'(cfg_ready), 32'd0);
    @(negedge clk);
    check("zero.cfg_ready_hi", 32'(cfg_ready), 32'd1);
    en = 1'b1;
    @(negedge clk);
    check("zero.state_run", 32'(state), 32'd2);
    tick_chk("zero0", 1'b1, 0, 0, 1'b0);
    tick_chk("zero1", 1'b1, 1, 1, 1'b0);

    // Asynchronous reset between clock edges
    #2;
    rst = 1'b1;
    #1;
    check("arst.mute",    32'(mute),    32'd1);
    check("arst.state",   32'(state),   32'd0);
    check("arst.wr_addr", 32'(wr_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst.refill", 32'(state), 32'd1);
    tick_chk("arst_fill", 1'b0, 0, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
